gf180_ram_arbiter: RTL and testbench
====================================

GF180_RAM_ARBITER -- requirements
Module: gf180_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, SRAM address width; fixed to the 256x8 macro.
REQ-002 Parameter DATA_W, 8, SRAM data width; fixed to the 256x8 macro.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 REQ[1:0]  input  2  per-port access request, one per requester.
REQ-006 WE[1:0]  input  2  per-port write (1) / read (0) select.
REQ-007 ADDR0, ADDR1  input  ADDR_W each  per-port address.
REQ-008 WDATA0, WDATA1  input  DATA_W each  per-port write data.
REQ-009 WMASK0, WMASK1  input  DATA_W each  per-port bit write-enable, active-high.
REQ-010 GNT[1:0]  output  2  one-hot grant; the access is accepted on the edge where GNT[i] is high.
REQ-011 RVALID[1:0]  output  2  read data valid, one cycle pulse per granted read.
REQ-012 RDATA0, RDATA1  output  DATA_W each  per-port held read data.
REQ-013 BUSY  output  1  high while the clear sequence runs.
REQ-014 RAM_CEN, RAM_GWEN  output  1 each  SRAM chip and global write enables, active-low.
REQ-015 RAM_A, RAM_D, RAM_WEN  output  ADDR_W / DATA_W / DATA_W  SRAM address, data and active-low bit write enables.
REQ-016 RAM_Q  input  DATA_W  SRAM read data; valid the cycle after a read edge.

Function
REQ-017 States: CLEAR and RUN; CLEAR exits to RUN after the access at address 255; RUN is terminal until reset.
REQ-018 In RUN, GNT is combinational from REQ and the round-robin pointer, with at most one bit high per cycle.
REQ-019 Arbitration: with one requester, grant it; with both, grant the port not granted most recently; pointer updates only on a grant.
REQ-020 Granted cycle: RAM_CEN=0; RAM_A, RAM_D, RAM_WEN=~WMASKi from the granted port; RAM_GWEN=~WE[i].
REQ-021 No grant: RAM_CEN=1, RAM_GWEN=1, RAM_WEN=all ones, RAM_A/RAM_D=0.
REQ-022 Read latency: RVALID[i] pulses exactly one cycle after a granted read; RDATAi is loaded from RAM_Q in that cycle and is equal to it combinationally.
REQ-023 RDATAi holds its last read value until that port's next read completes; writes do not update RDATA.
REQ-024 Back-to-back grants to either port every cycle are legal; throughput is one access per cycle.
REQ-025 A write with WMASK=0 still consumes a grant and drives RAM_CEN=0 with RAM_WEN all ones.
REQ-026 In CLEAR: GNT=0, BUSY=1, 8-bit counter drives RAM_A; each cycle is a write of 0 with RAM_WEN=0; counter increments 0..255; REQ is ignored.

Reset
REQ-027 RST asserted forces: state=CLEAR (RUN without the macro), counter=0, pointer favours port 0, RVALID=0, RDATA0/1=0, GNT=0, RAM_CEN=1.
REQ-028 RST mid-access aborts the access; any pending RVALID is dropped; the clear sequence restarts at 0.

Configuration
REQ-029 Macro GF180_RAM_ARB_CLEAR_EN: when defined, CLEAR runs for 256 cycles after reset; when undefined, there is no CLEAR state or counter, BUSY is tied 0, and reset enters RUN.

Structure
REQ-030 Shared package gf180_ram_pkg holds ADDR_W, DATA_W, RAM_DEPTH=256 and the state enum.
REQ-031 Sub-module rr_arb2 holds the 2-way round-robin grant and pointer; everything else stays in this module.

Verification
REQ-032 Reset with the macro defined -> BUSY=1 for 256 cycles, RAM_A goes 0..255, RAM_WEN=0, D=0; then BUSY=0 and GNT is active.
REQ-033 Port0 writes 0xA5 to 0x10, then port0 reads 0x10 -> RVALID[0] pulses one cycle after the read grant with RDATA0=0xA5.
REQ-034 Both ports request continuously -> GNT alternates 01, 10, 01, ... with no idle cycle.
REQ-035 Port1 writes 0xFF to 0x20 with WMASK1=0x0F after clear -> a later read returns 0x0F.
REQ-036 Assert RST during a granted read -> no RVALID, RDATA=0, and the clear restarts at address 0.

Source files
------------

// File: rtl/gf180_ram_pkg.sv
// Shared constants and FSM state type for the GF180 256x8 SRAM arbiter.
package gf180_ram_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 256;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/gf180_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer remembers the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // High when port 1 won most recently; reset value lets port 0 win the first tie.
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/gf180_ram_arbiter.sv
// Two-port arbiter in front of a single-port 256x8 GF180 SRAM macro.
// Define GF180_RAM_ARB_CLEAR_EN to zero the whole array after every reset.
module gf180_ram_arbiter
  import gf180_ram_pkg::*;
#(
  parameter int ADDR_W = gf180_ram_pkg::ADDR_W,
  parameter int DATA_W = gf180_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wmask0,
  input  logic [DATA_W-1:0] wmask1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_cen,
  output logic              ram_gwen,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic [DATA_W-1:0] ram_wen,
  input  logic [DATA_W-1:0] ram_q
);

  logic              clearing;
  logic              run;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;

`ifdef GF180_RAM_ARB_CLEAR_EN
  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  // Sweep every address once, then hand the RAM over to the ports for good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(RAM_DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  assign clearing = (state == ST_CLEAR) && !rst;
  assign busy     = (state == ST_CLEAR);
  assign clr_addr = clr_cnt;
`else
  assign clearing = 1'b0;
  assign busy     = 1'b0;
  assign clr_addr = '0;
`endif

  // Reset gates the grant path so no access can leak out while it is held.
  assign run = !rst && !clearing;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = '0;
    ram_d    = '0;
    if (clearing) begin
      ram_cen  = 1'b0;
      ram_gwen = 1'b0;
      ram_wen  = '0;
      ram_a    = clr_addr;
    end else if (gnt[0]) begin
      ram_cen  = 1'b0;
      ram_gwen = ~we[0];
      ram_wen  = ~wmask0;
      ram_a    = addr0;
      ram_d    = wdata0;
    end else if (gnt[1]) begin
      ram_cen  = 1'b0;
      ram_gwen = ~we[1];
      ram_wen  = ~wmask1;
      ram_a    = addr1;
      ram_d    = wdata1;
    end
  end

  // RAM_Q appears one cycle after a read edge; capture it then so it survives later accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 2'b00;
      hold0  <= '0;
      hold1  <= '0;
    end else begin
      rvalid <= gnt & ~we;
      if (rvalid[0]) begin
        hold0 <= ram_q;
      end
      if (rvalid[1]) begin
        hold1 <= ram_q;
      end
    end
  end

  assign rdata0 = rvalid[0] ? ram_q : hold0;
  assign rdata1 = rvalid[1] ? ram_q : hold1;

endmodule

// File: tb/tb_gf180_ram_arbiter.sv
// Self-checking bench for gf180_ram_arbiter with a behavioural SRAM and arbiter model.
// Expectations follow GF180_RAM_ARB_CLEAR_EN when the bench is built with it.
module tb_gf180_ram_arbiter;
  import gf180_ram_pkg::*;

`ifdef GF180_RAM_ARB_CLEAR_EN
  localparam int CLEAR_CYCLES = 256;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr0, addr1, wdata0, wdata1, wmask0, wmask1;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata0, rdata1;
  logic       busy, ram_cen, ram_gwen;
  logic [7:0] ram_a, ram_d, ram_wen;
  logic [7:0] ram_q = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf180_ram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wmask0(wmask0), .wmask1(wmask1),
    .gnt(gnt), .rvalid(rvalid), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .ram_cen(ram_cen), .ram_gwen(ram_gwen),
    .ram_a(ram_a), .ram_d(ram_d), .ram_wen(ram_wen), .ram_q(ram_q)
  );

  // SRAM macro: registered Q on reads, active-low bit write enables on writes.
  logic [7:0] sram [256];
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (ram_gwen) ram_q <= sram[ram_a];
      else          sram[ram_a] <= (sram[ram_a] & ram_wen) | (ram_d & ~ram_wen);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: memory contents, remaining clear cycles, last winner, pending reads.
  logic [7:0] gold [256];
  int         m_left = CLEAR_CYCLES;
  int         m_last = 1;
  int         m_gi;
  logic [1:0] m_pend = 2'b00;
  logic [7:0] m_pdata [2];
  logic [7:0] m_rdata [2];
  logic [1:0] e_gnt;
  logic       e_cen, e_gwen;
  logic [7:0] e_wen, e_a, e_d, p_a, p_d, p_m, e_r0, e_r1;

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_rvalid", 32'(rvalid), 32'h0);
      checkOutput("reset_rdata0", 32'(rdata0), 32'h0);
      checkOutput("reset_rdata1", 32'(rdata1), 32'h0);
      checkOutput("reset_cen", 32'(ram_cen), 32'h1);
      m_left = CLEAR_CYCLES;
      m_last = 1;
      m_pend = 2'b00;
      m_rdata[0] = 8'h00;
      m_rdata[1] = 8'h00;
    end else begin
      e_cen = 1'b1; e_gwen = 1'b1; e_wen = 8'hFF; e_a = 8'h00; e_d = 8'h00;
      e_gnt = 2'b00; m_gi = -1; p_a = 8'h00; p_d = 8'h00; p_m = 8'h00;
      if (m_left > 0) begin
        e_cen = 1'b0; e_gwen = 1'b0; e_wen = 8'h00; e_a = 8'(256 - m_left);
      end else if (req != 2'b00) begin
        if (req == 2'b11) m_gi = 1 - m_last;
        else              m_gi = req[1] ? 1 : 0;
        p_a = (m_gi == 1) ? addr1  : addr0;
        p_d = (m_gi == 1) ? wdata1 : wdata0;
        p_m = (m_gi == 1) ? wmask1 : wmask0;
        e_gnt[m_gi] = 1'b1;
        e_cen = 1'b0; e_gwen = ~we[m_gi]; e_wen = ~p_m; e_a = p_a; e_d = p_d;
      end
      e_r0 = m_pend[0] ? m_pdata[0] : m_rdata[0];
      e_r1 = m_pend[1] ? m_pdata[1] : m_rdata[1];
      checkOutput("gnt", 32'(gnt), 32'(e_gnt));
      checkOutput("rvalid", 32'(rvalid), 32'(m_pend));
      checkOutput("rdata0", 32'(rdata0), 32'(e_r0));
      checkOutput("rdata1", 32'(rdata1), 32'(e_r1));
      checkOutput("busy", 32'(busy), (m_left > 0) ? 32'h1 : 32'h0);
      checkOutput("ram_cen", 32'(ram_cen), 32'(e_cen));
      checkOutput("ram_gwen", 32'(ram_gwen), 32'(e_gwen));
      checkOutput("ram_wen", 32'(ram_wen), 32'(e_wen));
      checkOutput("ram_a", 32'(ram_a), 32'(e_a));
      checkOutput("ram_d", 32'(ram_d), 32'(e_d));
      m_rdata[0] = e_r0;
      m_rdata[1] = e_r1;
      m_pend = 2'b00;
      if (m_left > 0) begin
        gold[e_a] = 8'h00;
        m_left--;
      end else if (m_gi >= 0) begin
        if (we[m_gi]) begin
          gold[p_a] = (gold[p_a] & ~p_m) | (p_d & p_m);
        end else begin
          m_pend[m_gi]  = 1'b1;
          m_pdata[m_gi] = gold[p_a];
        end
        m_last = m_gi;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [7:0] a0, input logic [7:0] d0, input logic [7:0] m0,
                               input logic [7:0] a1, input logic [7:0] d1, input logic [7:0] m1);
    @(posedge clk);
    #1;
    req = r; we = w;
    addr0 = a0; wdata0 = d0; wmask0 = m0;
    addr1 = a1; wdata1 = d1; wmask1 = m1;
    @(negedge clk);
  endtask

  logic [1:0] alt_exp;
  logic [7:0] post_exp;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = 8'h00;
      gold[i] = 8'h00;
    end
    m_pdata[0] = 8'h00; m_pdata[1] = 8'h00;
    m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    rst = 1'b1;
    req = 2'b00; we = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    wmask0 = 8'h00; wmask1 = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("lit_reset_cen", 32'(ram_cen), 32'h1);
    checkOutput("lit_reset_gnt", 32'(gnt), 32'h0);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`ifdef GF180_RAM_ARB_CLEAR_EN
    checkOutput("lit_clear_busy", 32'(busy), 32'h1);
    checkOutput("lit_clear_first_a", 32'(ram_a), 32'h00);
    checkOutput("lit_clear_wen", 32'(ram_wen), 32'h00);
    for (int k = 1; k < 256; k++) begin
      applyStimulus(2'b11, 2'b00, 8'h05, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00);
      if (k == 255) checkOutput("lit_clear_last_a", 32'(ram_a), 32'hFF);
    end
`endif

    // Port 0 writes 0xA5 to 0x10 and reads it back.
    applyStimulus(2'b01, 2'b01, 8'h10, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_run_busy", 32'(busy), 32'h0);
    checkOutput("lit_wr_gnt", 32'(gnt), 32'h1);
    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_rd_gnt", 32'(gnt), 32'h1);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_rd_rvalid", 32'(rvalid), 32'h1);
    checkOutput("lit_rd_data", 32'(rdata0), 32'hA5);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_rd_hold", 32'(rdata0), 32'hA5);

    // Both ports request every cycle; port 0 won last, so port 1 leads.
    alt_exp = 2'b10;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 2'b00, 8'(k), 8'h00, 8'h00, 8'(k + 16), 8'h00, 8'h00);
      checkOutput("lit_alt_gnt", 32'(gnt), 32'(alt_exp));
      alt_exp = ~alt_exp;
    end

    // Port 1 masked write keeps only the low nibble.
    applyStimulus(2'b10, 2'b10, 8'h00, 8'h00, 8'h00, 8'h20, 8'hFF, 8'h0F);
    checkOutput("lit_mask_wen", 32'(ram_wen), 32'hF0);
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_mask_rdata1", 32'(rdata1), 32'h0F);

    // A zero-mask write still takes the RAM but changes nothing.
    applyStimulus(2'b01, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_zmask_cen", 32'(ram_cen), 32'h0);
    checkOutput("lit_zmask_wen", 32'(ram_wen), 32'hFF);
    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_zmask_rdata0", 32'(rdata0), 32'hA5);

    // Contended write and read of one address, then a plain read.
    applyStimulus(2'b11, 2'b01, 8'h30, 8'h3C, 8'hFF, 8'h30, 8'h00, 8'h00);
    applyStimulus(2'b11, 2'b01, 8'h30, 8'hC3, 8'hF0, 8'h30, 8'h00, 8'h00);
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset lands in the middle of a granted read.
    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_abort_gnt", 32'(gnt), 32'h1);
    #1;
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    checkOutput("lit_abort_rvalid", 32'(rvalid), 32'h0);
    checkOutput("lit_abort_rdata0", 32'(rdata0), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
`ifdef GF180_RAM_ARB_CLEAR_EN
    checkOutput("lit_reclear_a", 32'(ram_a), 32'h00);
    checkOutput("lit_reclear_busy", 32'(busy), 32'h1);
`endif
    for (int k = 0; k < 300 && busy; k++) begin
      applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    checkOutput("lit_reclear_done", 32'(busy), 32'h0);

    post_exp = (CLEAR_CYCLES > 0) ? 8'h00 : 8'hA5;
    applyStimulus(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("lit_post_reset_rdata0", 32'(rdata0), 32'(post_exp));
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
